qspis_wb_tmo: RTL and testbench



---
 rtl/qspis_pkg.sv | 10 +
 rtl/qspis_wb_tmo_if.sv | 15 +
 rtl/qspis_tmo_cnt.sv | 26 ++
 rtl/qspis_wb_tmo.sv | 112 +++++++++++
 tb/tb_qspis_wb_tmo.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/qspis_pkg.sv
// Shared types and constants for the QSPI slave Wishbone bridge stages.
package qspis_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic {RESP_ACK = 1'b0, RESP_ERR = 1'b1} resp_t;

    localparam int ERR_BUS = 0;
    localparam int ERR_TMO = 1;

    localparam logic [31:0] TMO_RDATA_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/qspis_wb_tmo_if.sv
// Classic Wishbone request/response bundle; dat_w flows master->slave, dat_r slave->master.
interface qspis_wb_tmo_if;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, adr, we, dat_w, sel, input  dat_r, ack, err);
    modport slave  (input  cyc, stb, adr, we, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/qspis_tmo_cnt.sv
// Saturating transaction-age counter; expire flags the last allowed cycle (TMO_CYC == 0 disables it).
module qspis_tmo_cnt #(
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(1023)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + ONE;
    end

    assign expire = (TMO_CYC != '0) && (cnt == TMO_CYC - ONE);
endmodule

// File: rtl/qspis_wb_tmo.sv
// Registered Wishbone pass-through between the QSPI slave and the fabric, with a per-access
// timeout that turns a hung slave into an error response and sticky error capture.
module qspis_wb_tmo
    import qspis_pkg::*;
#(
    parameter int               TMO_W     = 16,
    parameter logic [TMO_W-1:0] TMO_CYC   = TMO_W'(1023),
    parameter logic [31:0]      TMO_RDATA = TMO_RDATA_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    qspis_wb_tmo_if.slave         s,
    qspis_wb_tmo_if.master        m,
    input  logic                  err_clr_i,
    output logic [1:0]            err_sts_o,
    output logic [31:0]           err_adr_o
);
    state_t      state;
    resp_t       rsp;
    logic        accept;
    logic        in_req;
    logic        tmo_exp;
    logic        tmo;
    logic [1:0]  err_new;

    assign accept = (state == IDLE) && s.cyc && s.stb;
    assign in_req = (state == REQ) && s.cyc;
    // A fabric response in the expiring cycle still takes priority over the timeout.
    assign tmo    = in_req && tmo_exp && !m.ack && !m.err;

    always_comb begin
        rsp     = (m.err || tmo) ? RESP_ERR : RESP_ACK;
        err_new = '0;
        if (in_req) begin
            err_new[ERR_BUS] = m.err;
            err_new[ERR_TMO] = tmo;
        end
    end

    qspis_tmo_cnt #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmo_cnt (
        .clk    (sys_clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == REQ),
        .expire (tmo_exp)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m.cyc   <= 1'b0;
            m.stb   <= 1'b0;
            m.adr   <= '0;
            m.we    <= 1'b0;
            m.dat_w <= '0;
            m.sel   <= '0;
            s.ack   <= 1'b0;
            s.err   <= 1'b0;
            s.dat_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m.cyc   <= 1'b1;
                        m.stb   <= 1'b1;
                        m.adr   <= s.adr;
                        m.we    <= s.we;
                        m.dat_w <= s.dat_w;
                        m.sel   <= s.sel;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // Upstream abort: walk away silently, a late fabric ack lands in IDLE.
                    if (!s.cyc) begin
                        m.cyc <= 1'b0;
                        m.stb <= 1'b0;
                        state <= IDLE;
                    end else if (m.ack || m.err || tmo) begin
                        m.cyc   <= 1'b0;
                        m.stb   <= 1'b0;
                        s.ack   <= (rsp == RESP_ACK);
                        s.err   <= (rsp == RESP_ERR);
                        s.dat_r <= m.err ? 32'h0 : (tmo ? TMO_RDATA : m.dat_r);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    s.ack <= 1'b0;
                    s.err <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address latches only for the first error since the last clear; a clear in the
    // same cycle as a new error counts as "no prior error".
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_sts_o <= '0;
            err_adr_o <= '0;
        end else if (|err_new) begin
            if ((err_sts_o == '0) || err_clr_i)
                err_adr_o <= m.adr;
            err_sts_o <= (err_clr_i ? 2'b00 : err_sts_o) | err_new;
        end else if (err_clr_i) begin
            err_sts_o <= '0;
        end
    end
endmodule

// File: tb/tb_qspis_wb_tmo.sv
// Bench for qspis_wb_tmo: transaction-level reference model compared every cycle, plus directed scenarios.
module tb_qspis_wb_tmo;
    localparam logic [15:0] TMO = 16'd8;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        err_clr_i = 1'b0;
    logic [1:0]  err_sts_o;
    logic [31:0] err_adr_o;

    qspis_wb_tmo_if s();
    qspis_wb_tmo_if m();

    qspis_wb_tmo #(.TMO_W(16), .TMO_CYC(TMO), .TMO_RDATA(32'hFFFF_FFFF)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .s         (s),
        .m         (m),
        .err_clr_i (err_clr_i),
        .err_sts_o (err_sts_o),
        .err_adr_o (err_adr_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding access, its age, and a pending one-cycle response.
    bit          busy = 1'b0;
    int          age  = 0;
    int          rk   = 0;   // 0 none, 1 ack pulse, 2 err pulse
    logic [31:0] e_adr = '0, e_dat = '0, e_sdat = '0, e_eadr = '0;
    logic        e_we = 1'b0;
    logic [3:0]  e_sel = '0;
    logic [1:0]  e_sts = '0;
    logic        mf_bus, mf_tmo;

    assign mf_bus = busy && s.cyc && m.err;
    assign mf_tmo = busy && s.cyc && !m.err && !m.ack && (TMO != 0) && (age == int'(TMO) - 1);

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0; age <= 0; rk <= 0;
            e_adr <= '0; e_dat <= '0; e_sdat <= '0; e_eadr <= '0;
            e_we <= 1'b0; e_sel <= '0; e_sts <= '0;
        end else begin
            if (rk != 0) rk <= 0;
            else if (!busy) begin
                if (s.cyc && s.stb) begin
                    busy <= 1'b1; age <= 0;
                    e_adr <= s.adr; e_we <= s.we; e_dat <= s.dat_w; e_sel <= s.sel;
                end
            end
            else if (!s.cyc) busy <= 1'b0;
            else if (mf_bus) begin busy <= 1'b0; rk <= 2; e_sdat <= 32'h0; end
            else if (m.ack)  begin busy <= 1'b0; rk <= 1; e_sdat <= m.dat_r; end
            else if (mf_tmo) begin busy <= 1'b0; rk <= 2; e_sdat <= 32'hFFFF_FFFF; end
            else age <= age + 1;

            if (mf_bus || mf_tmo) begin
                if (e_sts == 2'b00 || err_clr_i) e_eadr <= e_adr;
                e_sts <= (err_clr_i ? 2'b00 : e_sts) | {mf_tmo, mf_bus};
            end else if (err_clr_i) e_sts <= 2'b00;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("m_cyc",   32'(m.cyc),     32'(busy));
            chk("m_stb",   32'(m.stb),     32'(busy));
            chk("m_adr",   m.adr,          e_adr);
            chk("m_we",    32'(m.we),      32'(e_we));
            chk("m_dat",   m.dat_w,        e_dat);
            chk("m_sel",   32'(m.sel),     32'(e_sel));
            chk("s_ack",   32'(s.ack),     32'(rk == 1));
            chk("s_err",   32'(s.err),     32'(rk == 2));
            chk("s_dat",   s.dat_r,        e_sdat);
            chk("err_sts", 32'(err_sts_o), 32'(e_sts));
            chk("err_adr", err_adr_o,      e_eadr);
        end
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Cycle 0 is the current cycle; the fabric answers in cycle lat (lat < 0: never).
    task automatic run(input logic [31:0] adr, input bit we, input logic [31:0] wd,
                       input logic [3:0] sel, input int lat, input bit ack, input bit err,
                       input logic [31:0] rd, input bit clr_at_resp, output int rc);
        s.cyc = 1'b1; s.stb = 1'b1; s.adr = adr; s.we = we; s.dat_w = wd; s.sel = sel;
        rc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick;
            m.ack = 1'b0; m.err = 1'b0; m.dat_r = '0; err_clr_i = 1'b0;
            if (s.ack || s.err) begin
                rc = c; s.cyc = 1'b0; s.stb = 1'b0;
                break;
            end
            if (c == lat) begin
                m.ack = ack; m.err = err; m.dat_r = rd; err_clr_i = clr_at_resp;
            end
        end
        if (rc < 0) begin
            checks++; errors++;
            $display("FAIL resp_wait act=none exp=response adr=%h", adr);
            s.cyc = 1'b0; s.stb = 1'b0;
        end
    endtask

    int rc;

    initial begin
        s.cyc = 0; s.stb = 0; s.adr = '0; s.we = 0; s.dat_w = '0; s.sel = '0;
        m.ack = 0; m.err = 0; m.dat_r = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_m_stb", 32'(m.stb), 32'h0);
        chk("rst_s_ack", 32'(s.ack), 32'h0);
        chk("rst_sts",   32'(err_sts_o), 32'h0);
        rst = 1'b0;
        tick;

        // Write, fabric acks in cycle 3
        run(32'h1000_0004, 1'b1, 32'hA5A5_5A5A, 4'hF, 3, 1'b1, 1'b0, 32'h0, 1'b0, rc);
        chk("wr_lat", 32'(rc), 32'd4);
        chk("wr_adr", m.adr, 32'h1000_0004);
        chk("wr_dat", m.dat_w, 32'hA5A5_5A5A);
        chk("wr_sel", 32'(m.sel), 32'hF);
        chk("wr_sts", 32'(err_sts_o), 32'h0);
        tick;
        chk("wr_pulse", 32'(s.ack), 32'h0);

        // Read, two wait states
        run(32'h2000_0000, 1'b0, 32'h0, 4'hF, 3, 1'b1, 1'b0, 32'h1234_5678, 1'b0, rc);
        chk("rd_lat", 32'(rc), 32'd4);
        chk("rd_dat", s.dat_r, 32'h1234_5678);
        chk("rd_stb_low", 32'(m.stb), 32'h0);
        tick;
        chk("rd_pulse", 32'(s.ack), 32'h0);
        chk("rd_hold", s.dat_r, 32'h1234_5678);

        // Silent fabric -> timeout after 8 REQ cycles
        run(32'h3000_0010, 1'b0, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h0, 1'b0, rc);
        chk("tmo_lat", 32'(rc), 32'd9);
        chk("tmo_err", 32'(s.err), 32'h1);
        chk("tmo_dat", s.dat_r, 32'hFFFF_FFFF);
        chk("tmo_sts", 32'(err_sts_o), 32'h2);
        chk("tmo_adr", err_adr_o, 32'h3000_0010);
        tick;
        err_clr_i = 1'b1;
        tick;
        err_clr_i = 1'b0;
        chk("clr_sts", 32'(err_sts_o), 32'h0);

        // ack and err together: err wins
        run(32'h4000_0000, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 1'b1, 32'h0, 1'b0, rc);
        chk("ae_lat", 32'(rc), 32'd2);
        chk("ae_err", 32'(s.err), 32'h1);
        chk("ae_ack", 32'(s.ack), 32'h0);
        chk("ae_sts", 32'(err_sts_o), 32'h1);
        chk("ae_adr", err_adr_o, 32'h4000_0000);
        tick;
        run(32'h5000_0000, 1'b0, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'h0, 1'b0, rc);
        chk("e2_dat", s.dat_r, 32'h0);
        chk("e2_adr", err_adr_o, 32'h4000_0000);
        tick;
        // Clear coinciding with a new error: the new error is the first one
        run(32'h6000_0000, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b1, 32'h0, 1'b1, rc);
        chk("ce_sts", 32'(err_sts_o), 32'h1);
        chk("ce_adr", err_adr_o, 32'h6000_0000);
        tick;
        err_clr_i = 1'b1;
        tick;
        err_clr_i = 1'b0;
        chk("clr2_sts", 32'(err_sts_o), 32'h0);

        // Abort in second REQ cycle, then late ack
        s.cyc = 1'b1; s.stb = 1'b1; s.adr = 32'h7000_0000; s.we = 1'b0;
        tick;
        tick;
        s.cyc = 1'b0; s.stb = 1'b0;
        tick;
        chk("ab_stb", 32'(m.stb), 32'h0);
        m.ack = 1'b1; m.dat_r = 32'hDEAD_BEEF;
        tick;
        m.ack = 1'b0; m.dat_r = '0;
        chk("ab_noresp", 32'({s.ack, s.err}), 32'h0);
        tick;
        chk("ab_noresp2", 32'({s.ack, s.err}), 32'h0);
        run(32'h8000_0000, 1'b0, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, rc);
        chk("ab_next_lat", 32'(rc), 32'd2);
        chk("ab_next_dat", s.dat_r, 32'hCAFE_F00D);
        tick;

        // Asynchronous reset in the middle of REQ
        s.cyc = 1'b1; s.stb = 1'b1; s.adr = 32'h9000_0000;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("ar_stb", 32'(m.stb), 32'h0);
        chk("ar_adr", m.adr, 32'h0);
        chk("ar_sdat", s.dat_r, 32'h0);
        chk("ar_eadr", err_adr_o, 32'h0);
        s.cyc = 1'b0; s.stb = 1'b0;
        tick;
        tick;
        #2 rst = 1'b0;
        tick;
        run(32'hA000_0000, 1'b0, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h0BAD_CAFE, 1'b0, rc);
        chk("ar_next_lat", 32'(rc), 32'd2);
        chk("ar_next_dat", s.dat_r, 32'h0BAD_CAFE);
        repeat (3) tick;

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
